// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: fetch FSM state encoding and the default reset fetch address.
// Ports:   none (package).

package ifu_pkg;

   // RUN: may issue a request; WAIT: one request outstanding;
   // DROP: the outstanding response belongs to a flushed path and is discarded.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } ifu_state_e;

   localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
   localparam int          IFU_DEPTH    = 2;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - circular {pc, inst} queue between instruction memory and the D-pipe
//
// Purpose: DEPTH-entry queue with push, pop and flush; head entry is read straight
//          from the storage registers, so the head never depends on the push port.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   flush_i                   empty the queue (wins over push)
//   push_i, push_pc_i/inst_i  write one entry at the tail
//   pop_i                     retire the head entry
//   count_o                   number of valid entries (0..DEPTH)
//   head_pc_o, head_inst_o    head entry contents

module ifu_fifo #(
   parameter int PC_W   = 64,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [PC_W-1:0]            push_pc_i,
   input  logic [INST_W-1:0]          push_inst_i,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [PC_W-1:0]            head_pc_o,
   output logic [INST_W-1:0]          head_inst_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic do_push;
   assign do_push = push_i & ~flush_i & ~reset;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_i && !pop_i)      count_q <= count_q + 1'b1;
         else if (pop_i && !push_i) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         pc_mem_q[wr_ptr_q]   <= push_pc_i;
         inst_mem_q[wr_ptr_q] <= push_inst_i;
      end
   end

   assign count_o     = count_q;
   assign head_pc_o   = pc_mem_q[rd_ptr_q];
   assign head_inst_o = inst_mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit, producer side of the D-pipe handshake
//
// Purpose: holds the fetch PC, issues one instruction-memory read at a time,
//          queues returned {pc, inst} pairs and presents them to the decoder.
//          A redirect flushes queued entries and marks an in-flight read stale.
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   redirect_valid_i, redirect_pc_i       redirect request and target (bits [1:0] ignored)
//   imem_req_valid_o/addr_o, ready_i      read request channel
//   imem_rsp_valid_i, imem_rsp_data_i     read response (in order, one per request)
//   f_valid_o, D_ready_i, pc_o, inst_o    D-pipe output channel

module ifu
   import ifu_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter int              INST_W   = 32,
   parameter int              DEPTH    = IFU_DEPTH,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               redirect_valid_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               imem_req_valid_o,
   output logic [PC_W-1:0]    imem_req_addr_o,
   input  logic               imem_req_ready_i,
   input  logic               imem_rsp_valid_i,
   input  logic [INST_W-1:0]  imem_rsp_data_i,
   output logic               f_valid_o,
   input  logic               D_ready_i,
   output logic [PC_W-1:0]    pc_o,
   output logic [INST_W-1:0]  inst_o
);

   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   ifu_state_e      state_q;
   logic [PC_W-1:0] fetch_pc_q;
   logic [PC_W-1:0] req_pc_q;
   logic [CW-1:0]   count;
   logic [PC_W-1:0] redirect_tgt;
   logic            req_fire;
   logic            push;
   logic            pop;

   assign redirect_tgt = {redirect_pc_i[PC_W-1:2], 2'b00};

   // A redirect withdraws any request this cycle; the slot check keeps a
   // returning response from ever overflowing the queue.
   assign imem_req_valid_o = ~reset & (state_q == ST_RUN) & (count < DEPTH_C) & ~redirect_valid_i;
   assign imem_req_addr_o  = fetch_pc_q;
   assign req_fire         = imem_req_valid_o & imem_req_ready_i;

   assign f_valid_o = ~reset & (count != '0) & ~redirect_valid_i;
   assign pop       = f_valid_o & D_ready_i;
   assign push      = (state_q == ST_WAIT) & imem_rsp_valid_i & ~redirect_valid_i;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
      end else if (redirect_valid_i) begin
         fetch_pc_q <= redirect_tgt;
         // An in-flight read becomes stale unless its response is arriving now.
         if (state_q != ST_RUN) state_q <= imem_rsp_valid_i ? ST_RUN : ST_DROP;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (req_fire) begin
                  req_pc_q   <= fetch_pc_q;
                  fetch_pc_q <= fetch_pc_q + PC_W'(4);
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT, ST_DROP: begin
               if (imem_rsp_valid_i) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   ifu_fifo #(
      .PC_W   (PC_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .flush_i     (redirect_valid_i),
      .push_i      (push),
      .push_pc_i   (req_pc_q),
      .push_inst_i (imem_rsp_data_i),
      .pop_i       (pop),
      .count_o     (count),
      .head_pc_o   (pc_o),
      .head_inst_o (inst_o)
   );

   // Memory protocol: no response without an outstanding request, and a
   // pending request may only be withdrawn by a redirect.
   assert property (@(posedge clock) disable iff (reset)
      !(imem_rsp_valid_i && state_q == ST_RUN));
   assert property (@(posedge clock) disable iff (reset)
      (imem_req_valid_o && !imem_req_ready_i) |=>
         (redirect_valid_i || (imem_req_valid_o && $stable(imem_req_addr_o))));

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu against a queue-based fetch model

module tb_ifu;

   localparam int          DEPTH  = 2;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic [63:0] imem_req_addr_o;
   logic        imem_req_ready_i = 1'b0;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        f_valid_o;
   logic        D_ready_i = 1'b0;
   logic [63:0] pc_o;
   logic [31:0] inst_o;

   always #5 clock = ~clock;

   ifu dut (
      .clock            (clock),
      .reset            (reset),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .f_valid_o        (f_valid_o),
      .D_ready_i        (D_ready_i),
      .pc_o             (pc_o),
      .inst_o           (inst_o)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Model: next fetch address, one outstanding read (possibly stale), queue of fetched pairs.
   ent_t        m_q[$];
   logic [63:0] m_pc;
   logic [63:0] m_req_pc;
   bit          m_out;
   bit          m_stale;

   // Memory environment
   bit          mem_busy;
   int          mem_cnt;
   logic [63:0] mem_addr;

   // Stimulus knobs
   int          p_ready, p_dready, p_redir, p_reset_pm, fixed_lat;
   bit          force_redir, force_reset;
   logic [63:0] force_pc;

   int          checks, errors, cyc;
   logic [63:0] hs_addr[$];
   int          hs_cyc[$];
   int          fv_first;
   logic [63:0] fv_first_pc;
   bit          saw_pc8;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      hs_addr.delete();
      hs_cyc.delete();
      fv_first = -1;
      saw_pc8  = 1'b0;
   endtask

   task automatic step();
      bit exp_rv, exp_fv, lat_set;
      int lat;
      @(posedge clock);
      #1;
      reset = force_reset || (p_reset_pm > 0 && $urandom_range(0, 999) < p_reset_pm);
      if (force_redir) begin
         redirect_valid_i = 1'b1;
         redirect_pc_i    = force_pc;
         force_redir      = 1'b0;
      end else begin
         redirect_valid_i = ($urandom_range(0, 99) < p_redir);
         if ($urandom_range(0, 3) == 0)
            redirect_pc_i = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
         else
            redirect_pc_i = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 4095))};
      end
      imem_req_ready_i = ($urandom_range(0, 99) < p_ready);
      D_ready_i        = ($urandom_range(0, 99) < p_dready);
      if (mem_busy && mem_cnt == 0) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = inst_of(mem_addr);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = $urandom;
         if (mem_busy) mem_cnt--;
      end

      @(negedge clock);
      exp_rv = !reset && !m_out && (m_q.size() < DEPTH) && !redirect_valid_i;
      exp_fv = !reset && (m_q.size() != 0) && !redirect_valid_i;
      chk("req_valid", imem_req_valid_o, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr_o, m_pc);
      chk("f_valid", f_valid_o, exp_fv);
      if (exp_fv && f_valid_o) begin
         chk("pc_o", pc_o, m_q[0].pc);
         chk("inst_o", inst_o, m_q[0].inst);
      end

      if (imem_req_valid_o && imem_req_ready_i) begin
         hs_addr.push_back(imem_req_addr_o);
         hs_cyc.push_back(cyc);
      end
      if (f_valid_o && fv_first < 0) begin
         fv_first    = cyc;
         fv_first_pc = pc_o;
      end
      if (f_valid_o && pc_o == 64'h0000_0000_8000_0008) saw_pc8 = 1'b1;

      if (reset) begin
         m_pc     = RST_PC;
         m_out    = 1'b0;
         m_stale  = 1'b0;
         m_q.delete();
         mem_busy = 1'b0;
      end else begin
         if (exp_fv && D_ready_i) void'(m_q.pop_front());
         if (imem_rsp_valid_i) begin
            if (m_out && !m_stale && !redirect_valid_i)
               m_q.push_back('{pc: m_req_pc, inst: imem_rsp_data_i});
            m_out    = 1'b0;
            mem_busy = 1'b0;
         end
         if (redirect_valid_i) begin
            m_q.delete();
            m_pc = {redirect_pc_i[63:2], 2'b00};
            if (m_out) m_stale = 1'b1;
         end
         if (exp_rv && imem_req_ready_i) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 64'd4;
            m_out    = 1'b1;
            m_stale  = 1'b0;
         end
         if (imem_req_valid_o && imem_req_ready_i) begin
            lat_set  = (fixed_lat > 0);
            lat      = lat_set ? fixed_lat : int'($urandom_range(1, 3));
            mem_busy = 1'b1;
            mem_addr = imem_req_addr_o;
            mem_cnt  = lat - 1;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      p_reset_pm  = 0;
      force_reset = 1'b1;
      repeat (3) step();
      force_reset = 1'b0;
      clear_logs();
   endtask

   task automatic run_until_hs(input int max, output logic [63:0] a, output int c);
      int n0;
      n0 = hs_addr.size();
      a  = 'x;
      c  = -1;
      for (int i = 0; i < max; i++) begin
         step();
         if (hs_addr.size() > n0) begin
            a = hs_addr[n0];
            c = hs_cyc[n0];
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL hs_timeout: no request handshake within %0d cycles (cycle %0d)", max, cyc);
   endtask

   initial begin
      logic [63:0] a;
      int          c, rc, n0, nv;
      checks = 0; errors = 0; cyc = 0;
      force_redir = 0; force_reset = 0; force_pc = '0;
      mem_busy = 0; mem_cnt = 0; mem_addr = '0;
      m_pc = RST_PC; m_req_pc = RST_PC; m_out = 0; m_stale = 0;
      p_redir = 0; p_reset_pm = 0;
      clear_logs();

      // 1: always-ready memory, 1-cycle response
      p_ready = 100; p_dready = 100; fixed_lat = 1;
      do_reset();
      repeat (12) step();
      chk("p1_hs_count", hs_addr.size(), 6);
      if (hs_addr.size() >= 3) begin
         chk("p1_addr0", hs_addr[0], 64'h8000_0000);
         chk("p1_addr1", hs_addr[1], 64'h8000_0004);
         chk("p1_addr2", hs_addr[2], 64'h8000_0008);
         chk("p1_req_spacing", hs_cyc[1] - hs_cyc[0], 2);
         chk("p1_fvalid_latency", fv_first - hs_cyc[0], 2);
         chk("p1_first_pc", fv_first_pc, 64'h8000_0000);
      end

      // 2: consumer stalled -> exactly DEPTH requests, head holds
      p_dready = 0;
      do_reset();
      repeat (10) step();
      chk("p2_hs_count", hs_addr.size(), DEPTH);
      chk("p2_fvalid", f_valid_o, 1);
      chk("p2_head_pc", pc_o, 64'h8000_0000);
      chk("p2_req_valid_off", imem_req_valid_o, 0);
      p_dready = 100;
      repeat (4) step();

      // 3: redirect while the read for 0x8000_0008 is outstanding (3-cycle memory)
      fixed_lat = 3;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (hs_addr.size() > 0 && hs_addr[hs_addr.size()-1] == 64'h8000_0008) break;
         step();
      end
      force_redir = 1'b1; force_pc = 64'h8000_0100;
      step();
      n0 = hs_addr.size();
      repeat (15) step();
      chk("p3_stale_never_seen", saw_pc8, 0);
      chk("p3_hs_after_redirect", hs_addr.size() > n0, 1);
      if (hs_addr.size() > n0) chk("p3_target_addr", hs_addr[n0], 64'h8000_0100);

      // 4: redirect coincides with a response while the queue holds an entry
      fixed_lat = 1; p_dready = 0;
      do_reset();
      run_until_hs(5, a, c);
      run_until_hs(5, a, c);
      force_redir = 1'b1; force_pc = 64'h8000_0200;
      p_dready = 100;
      step();
      rc = cyc - 1;
      chk("p4_fvalid_in_redirect", f_valid_o, 0);
      run_until_hs(5, a, c);
      chk("p4_target_addr", a, 64'h8000_0200);
      chk("p4_req_next_cycle", c, rc + 1);
      repeat (2) step();
      chk("p4_fvalid_target", f_valid_o, 1);
      chk("p4_pc_target", pc_o, 64'h8000_0200);

      // 5: misaligned target and PC wrap
      do_reset();
      run_until_hs(5, a, c);
      force_redir = 1'b1; force_pc = 64'h8000_0102;
      step();
      run_until_hs(5, a, c);
      chk("p5_aligned_target", a, 64'h8000_0100);
      force_redir = 1'b1; force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      run_until_hs(5, a, c);
      chk("p5_top_addr", a, 64'hFFFF_FFFF_FFFF_FFFC);
      run_until_hs(5, a, c);
      chk("p5_wrap_addr", a, 64'h0);

      // 6: memory not ready, then reset while a read is outstanding
      p_ready = 0;
      do_reset();
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (imem_req_valid_o) nv++;
         chk("p6_stall_addr", imem_req_addr_o, 64'h8000_0000);
      end
      chk("p6_stall_valid_cycles", nv, 5);
      p_ready = 100; fixed_lat = 3;
      run_until_hs(5, a, c);
      run_until_hs(10, a, c);
      chk("p6_second_addr", a, 64'h8000_0004);
      step();
      force_reset = 1'b1;
      step();
      chk("p6_fvalid_in_reset", f_valid_o, 0);
      chk("p6_req_in_reset", imem_req_valid_o, 0);
      step();
      force_reset = 1'b0;
      run_until_hs(5, a, c);
      chk("p6_after_reset_addr", a, 64'h8000_0000);

      // Random traffic
      p_ready = 70; p_dready = 60; fixed_lat = 0;
      do_reset();
      p_redir = 6; p_reset_pm = 3;
      repeat (4000) step();
      chk("rand_activity", hs_addr.size() > 200, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
